// File: rtl/trav_pkg.sv
// trav_pkg: shared types and constants for the traversal decision unit.
`default_nettype none

package trav_pkg;

  // Child-visit order selected by the traversal math stage
  typedef enum logic [1:0] {
    ONLY_LOW   = 2'd0,
    ONLY_HIGH  = 2'd1,
    LO_THEN_HI = 2'd2,
    HI_THEN_LO = 2'd3
  } trav_case_e;

  // Bit positions inside the 4-bit short-stack op vector {push,pop,upd_rest,upd_max}
  localparam int SS_OP_PUSH     = 3;
  localparam int SS_OP_POP      = 2;
  localparam int SS_OP_UPD_REST = 1;
  localparam int SS_OP_UPD_MAX  = 0;

endpackage

`default_nettype wire

// File: rtl/trav_fifo.sv
// trav_fifo: synchronous FIFO with arbitrary (non power-of-2) depth and free-entry count.
`default_nettype none

module trav_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 15,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             rd_i,
  output logic [W-1:0]     rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] num_left_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;

  assign rdata_o    = mem_q[rptr_q];
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign num_left_o = CNT_W'(DEPTH) - cnt_q;

  // Pointers and occupancy; pointers wrap explicitly since DEPTH need not be a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_i)
        wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      if (rd_i)
        rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      if (wr_i && !rd_i)
        cnt_q <= cnt_q + CNT_W'(1);
      else if (rd_i && !wr_i)
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_i)
      mem_q[wptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/trav_hold_reg.sv
// trav_hold_reg: single-entry output register; holds valid and data stable while stalled.
`default_nettype none

module trav_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         stall_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  // The entry can take new data when empty or when its current content leaves this cycle
  assign free_o = ~valid_o | ~stall_i;

  // Load has priority; otherwise an unstalled entry retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (!stall_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trav_decide_unit.sv
// trav_decide_unit: decodes buffered traversal decisions into short-stack ops and
// next-node fetches. Optional statistics counters are enabled by TRAV_DECIDE_STATS_EN.
`default_nettype none

module trav_decide_unit
  import trav_pkg::*;
#(
  parameter int SS_DEPTH = 4,
  parameter int IN_DEPTH = 15,
  parameter int RAYID_W  = 9,
  parameter int NODE_W   = 16,
  parameter int SSP_W    = $clog2(SS_DEPTH),
  parameter int SSN_W    = $clog2(SS_DEPTH + 1),
  parameter int CNT_W    = $clog2(IN_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_stall,
  input  logic [RAYID_W-1:0] in_ray_id,
  input  logic               in_is_shadow,
  input  logic [SSP_W-1:0]   in_ss_wptr,
  input  logic [SSN_W-1:0]   in_ss_num,
  input  logic [NODE_W-1:0]  in_parent_id,
  input  logic [NODE_W-1:0]  in_right_id,
  input  logic               in_low_empty,
  input  logic               in_high_empty,
  input  logic               in_restnode,
  input  logic [1:0]         in_case,
  input  logic [31:0]        in_t_max,
  input  logic [31:0]        in_t_min,
  input  logic [31:0]        in_t_mid,
  output logic [CNT_W-1:0]   num_left,
  output logic               ss_valid,
  input  logic               ss_stall,
  output logic [RAYID_W-1:0] ss_ray_id,
  output logic [3:0]         ss_op,
  output logic [NODE_W-1:0]  ss_push_id,
  output logic [NODE_W-1:0]  ss_rest_id,
  output logic [31:0]        ss_t_max,
  output logic               tarb_valid,
  input  logic               tarb_stall,
  output logic [RAYID_W-1:0] tarb_ray_id,
  output logic               tarb_is_shadow,
  output logic [SSP_W-1:0]   tarb_ss_wptr,
  output logic [SSN_W-1:0]   tarb_ss_num,
  output logic [NODE_W-1:0]  tarb_node_id,
  output logic               tarb_restnode,
  output logic [31:0]        tarb_t_max,
  output logic [31:0]        tarb_t_min
`ifdef TRAV_DECIDE_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_push,
  output logic [31:0]        stat_pop,
  output logic [31:0]        stat_tarb,
  output logic [31:0]        stat_ovf
`endif
);

  localparam int REC_W  = RAYID_W + 1 + SSP_W + SSN_W + 2 * NODE_W + 5 + 96;
  localparam int SS_W   = RAYID_W + 4 + 2 * NODE_W + 32;
  localparam int TARB_W = RAYID_W + 1 + SSP_W + SSN_W + NODE_W + 1 + 64;

  logic [REC_W-1:0]   rec_in, rec_head;
  logic               head_empty, fifo_full, deq, wr;
  logic [RAYID_W-1:0] h_ray_id;
  logic               h_shadow, h_l, h_h, h_rest;
  logic [SSP_W-1:0]   h_wptr;
  logic [SSN_W-1:0]   h_num;
  logic [NODE_W-1:0]  h_parent, h_right, h_low_id;
  logic [1:0]         h_case;
  logic [31:0]        h_tmax, h_tmin, h_tmid;

  assign rec_in = {in_ray_id, in_is_shadow, in_ss_wptr, in_ss_num, in_parent_id, in_right_id,
                   in_low_empty, in_high_empty, in_restnode, in_case, in_t_max, in_t_min, in_t_mid};
  assign {h_ray_id, h_shadow, h_wptr, h_num, h_parent, h_right,
          h_l, h_h, h_rest, h_case, h_tmax, h_tmin, h_tmid} = rec_head;

  // A full FIFO still accepts when the head leaves in the same cycle
  assign wr       = in_valid & (~fifo_full | deq);
  assign in_stall = fifo_full & ~deq;

  trav_fifo #(.W(REC_W), .DEPTH(IN_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk(clk), .rst(rst), .wr_i(wr), .wdata_i(rec_in), .rd_i(deq),
    .rdata_o(rec_head), .empty_o(head_empty), .full_o(fifo_full), .num_left_o(num_left)
  );

  // ---- head decode ----
  logic c_lo, c_hi, c_lh, c_hl;
  logic op_push, op_pop, op_rest, op_max, ss_need, tarb_need, near_first;
  logic [SSP_W-1:0] wptr_d;
  logic [SSN_W-1:0] num_d;

  assign c_lo = (h_case == ONLY_LOW);
  assign c_hi = (h_case == ONLY_HIGH);
  assign c_lh = (h_case == LO_THEN_HI);
  assign c_hl = (h_case == HI_THEN_LO);
  assign h_low_id = h_parent + NODE_W'(1);

  assign op_pop  = (c_lo & h_l) | (c_hi & h_h) | (h_l & h_h);
  assign op_push = ~h_l & ~h_h & (c_lh | c_hl);
  assign op_rest = h_rest & op_push;
  assign op_max  = h_rest & ((c_lh & h_h) | (c_hl & h_l));

  assign ss_need   = op_push | op_pop | op_rest | op_max;
  assign tarb_need = ~op_pop;

  // The first-visited child of a two-child case takes the near half of the interval
  assign near_first = (c_lh & ~h_l) | (c_hl & ~h_h);

  // Pointer advances with natural wrap; occupancy saturates at the stack depth
  assign wptr_d = op_push ? h_wptr + SSP_W'(1) : h_wptr;
  assign num_d  = (op_push && h_num != SSN_W'(SS_DEPTH)) ? h_num + SSN_W'(1) : h_num;

  logic [SS_W-1:0]   ss_din, ss_dout;
  logic [TARB_W-1:0] tarb_din, tarb_dout;
  logic [3:0]        op_vec;
  logic [NODE_W-1:0] next_node;
  logic [31:0]       next_tmax, next_tmin;
  logic              ss_free, tarb_free;

  always_comb begin
    op_vec                 = '0;
    op_vec[SS_OP_PUSH]     = op_push;
    op_vec[SS_OP_POP]      = op_pop;
    op_vec[SS_OP_UPD_REST] = op_rest;
    op_vec[SS_OP_UPD_MAX]  = op_max;
  end

  assign next_node = (c_lo | (c_lh & ~h_l) | (c_hl & h_h)) ? h_low_id : h_right;
  assign next_tmin = (c_lo | c_hi | near_first) ? h_tmin : h_tmid;
  assign next_tmax = (c_lo | c_hi) ? h_tmax : (near_first ? h_tmid : h_tmax);

  assign ss_din   = {h_ray_id, op_vec, (c_lh ? h_right : h_low_id), h_parent, h_tmax};
  assign tarb_din = {h_ray_id, h_shadow, wptr_d, num_d, next_node,
                     h_rest & ~op_push, next_tmax, next_tmin};

  // All-or-nothing issue: the head leaves only when every port it needs is free
  assign deq = ~head_empty & (~ss_need | ss_free) & (~tarb_need | tarb_free);

  trav_hold_reg #(.W(SS_W)) u_ss_hold (
    .clk(clk), .rst(rst), .load_i(deq & ss_need), .data_i(ss_din), .stall_i(ss_stall),
    .valid_o(ss_valid), .data_o(ss_dout), .free_o(ss_free)
  );

  trav_hold_reg #(.W(TARB_W)) u_tarb_hold (
    .clk(clk), .rst(rst), .load_i(deq & tarb_need), .data_i(tarb_din), .stall_i(tarb_stall),
    .valid_o(tarb_valid), .data_o(tarb_dout), .free_o(tarb_free)
  );

  assign {ss_ray_id, ss_op, ss_push_id, ss_rest_id, ss_t_max} = ss_dout;
  assign {tarb_ray_id, tarb_is_shadow, tarb_ss_wptr, tarb_ss_num, tarb_node_id,
          tarb_restnode, tarb_t_max, tarb_t_min} = tarb_dout;

`ifdef TRAV_DECIDE_STATS_EN
  logic [31:0] push_q, pop_q, tarb_q, ovf_q;

  assign stat_push = push_q;
  assign stat_pop  = pop_q;
  assign stat_tarb = tarb_q;
  assign stat_ovf  = ovf_q;

  // Saturating event counters updated on each dequeue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q <= '0; pop_q <= '0; tarb_q <= '0; ovf_q <= '0;
    end else if (stat_clr) begin
      push_q <= '0; pop_q <= '0; tarb_q <= '0; ovf_q <= '0;
    end else if (deq) begin
      if (op_push && push_q != '1)   push_q <= push_q + 32'd1;
      if (op_pop && pop_q != '1)     pop_q  <= pop_q + 32'd1;
      if (tarb_need && tarb_q != '1) tarb_q <= tarb_q + 32'd1;
      if (op_push && h_num == SSN_W'(SS_DEPTH) && ovf_q != '1) ovf_q <= ovf_q + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_drop: assert property (@(posedge clk) disable iff (rst) !(in_valid && in_stall))
    else $error("trav_decide_unit: record dropped while FIFO full");
  a_no_both_empty: assert property (@(posedge clk) disable iff (rst) !(!head_empty && h_l && h_h))
    else $error("trav_decide_unit: both children empty at FIFO head");
`endif

endmodule

`default_nettype wire
